// File: rtl/square_seq_if.sv
// square_seq_if: sample-in / result-out valid-ready handshake for the squarer
interface square_seq_if #(parameter int DATA_W = 16);
  logic [DATA_W-1:0] data_i;
  logic              valid_i;
  logic              ready_o;
  logic [DATA_W-1:0] data_o;
  logic              valid_o;
  logic              ready_i;
  modport slave  (input data_i, valid_i, ready_i, output ready_o, data_o, valid_o);
  modport master (output data_i, valid_i, ready_i, input ready_o, data_o, valid_o);
endinterface

// File: rtl/square_seq.sv
// square_seq: signed fixed-point squarer, sign(x)*floor(|x|^2 >> FRAC_W) saturated,
// built on a DATA_W-iteration shift-add multiplier.
module square_seq #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 15
) (
  input logic          clk_i,
  input logic          rst_ni,
  square_seq_if.slave  bus
);
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [2*DATA_W-1:0] MAXN = {{DATA_W{1'b0}}, 1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [2*DATA_W-1:0] MAXP = MAXN - 1'b1;
  typedef enum logic [1:0] {IDLE, MUL, SCALE, HOLD} state_t;
  state_t              state, state_nx;
  logic [2*DATA_W-1:0] acc, mcand, r;
  logic [DATA_W-1:0]   mult, mag, sat, res;
  logic [CW-1:0]       cnt;
  logic                neg, done;
  assign mag  = bus.data_i[DATA_W-1] ? -bus.data_i : bus.data_i;
  assign done = cnt == CW'(DATA_W);
  always_comb begin
    r           = acc >> FRAC_W;
    sat         = neg ? (r > MAXN ? MAXN[DATA_W-1:0] : r[DATA_W-1:0])
                      : (r > MAXP ? MAXP[DATA_W-1:0] : r[DATA_W-1:0]);
    res         = neg ? -sat : sat;
    bus.ready_o = state == IDLE;
    bus.valid_o = state == HOLD;
    state_nx    = state;
    case (state)
      IDLE:    state_nx = bus.valid_i ? MUL : IDLE;
      MUL:     state_nx = done ? SCALE : MUL;
      SCALE:   state_nx = HOLD;
      default: state_nx = bus.ready_i ? IDLE : HOLD;
    endcase
  end
  // MUL spends one extra cycle after the last iteration, giving DATA_W+2 edges of latency
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      acc        <= '0;
      mcand      <= '0;
      mult       <= '0;
      cnt        <= '0;
      neg        <= 1'b0;
      bus.data_o <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (bus.valid_i) begin
          mcand <= {{DATA_W{1'b0}}, mag};
          mult  <= mag;
          acc   <= '0;
          cnt   <= '0;
          neg   <= bus.data_i[DATA_W-1];
        end
        MUL: if (!done) begin
          acc   <= mult[0] ? acc + mcand : acc;
          mcand <= mcand << 1;
          mult  <= mult >> 1;
          cnt   <= cnt + 1'b1;
        end
        SCALE:   bus.data_o <= res;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_square_seq.sv
// tb_square_seq: random and directed squaring checked against an arithmetic model,
// two DUTs in lockstep (FRAC_W=15 and FRAC_W=14).
module tb_square_seq;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk_i = ~clk_i;
  square_seq_if #(.DATA_W(16)) ifa ();
  square_seq_if #(.DATA_W(16)) ifb ();
  square_seq #(.DATA_W(16), .FRAC_W(15)) dut_a (.clk_i(clk_i), .rst_ni(rst_ni), .bus(ifa.slave));
  square_seq #(.DATA_W(16), .FRAC_W(14)) dut_b (.clk_i(clk_i), .rst_ni(rst_ni), .bus(ifb.slave));

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sq(input int x, input int fw);
    longint m = x < 0 ? -longint'(x) : longint'(x);
    longint q = (m * m) >>> fw;
    if (x < 0) return -int'(q > 32768 ? 32768 : q);
    return int'(q > 32767 ? 32767 : q);
  endfunction

  function automatic int isqrt(input longint v);
    longint s = longint'($sqrt(real'(v)));
    while (s * s > v) s--;
    while ((s + 1) * (s + 1) <= v) s++;
    return int'(s);
  endfunction

  task automatic drive(input int x, input logic v);
    ifa.data_i = 16'(x); ifb.data_i = 16'(x);
    ifa.valid_i = v;     ifb.valid_i = v;
  endtask

  task automatic set_ready(input logic v);
    ifa.ready_i = v; ifb.ready_i = v;
  endtask

  task automatic wait_ready;
    int n = 0;
    while (!ifa.ready_o && n < 50) begin @(negedge clk_i); n++; end
    chk("ready_in", {31'd0, ifa.ready_o & ifb.ready_o}, 1);
  endtask

  task automatic run(input int x, input int bp, output int got);
    int n = 0;
    int ea = sq(x, 15);
    wait_ready();
    drive(x, 1'b1);
    @(posedge clk_i); #1;
    drive(int'($urandom), 1'b0);
    while (!ifa.valid_o && n < 40) begin @(posedge clk_i); #1; n++; end
    got = int'($signed(ifa.data_o));
    chk("latency", n, 18);
    chk("valid_b", {31'd0, ifb.valid_o}, 1);
    chk("data_a", got, ea);
    chk("data_b", int'($signed(ifb.data_o)), sq(x, 14));
    if (ifa.ready_i) begin
      @(posedge clk_i); #1;
      chk("drop", {31'd0, ifa.valid_o}, 0);
    end else begin
      repeat (bp) begin
        drive(int'($urandom), 1'b1);
        @(posedge clk_i); #1;
        chk("bp_valid", {31'd0, ifa.valid_o}, 1);
        chk("bp_data", int'($signed(ifa.data_o)), ea);
        chk("bp_ready", {31'd0, ifa.ready_o}, 0);
      end
      drive(0, 1'b0);
      set_ready(1'b1);
      @(posedge clk_i); #1;
      set_ready(1'b0);
      chk("hs_valid", {31'd0, ifa.valid_o}, 0);
      chk("hs_ready", {31'd0, ifa.ready_o}, 1);
      chk("hs_keep", int'($signed(ifa.data_o)), ea);
    end
  endtask

  initial begin
    int got, x, s, y;
    int dir[8] = '{16384, -16384, 0, 32767, -32768, 1, -1, 8192};
    drive(0, 1'b0);
    set_ready(1'b0);
    #1;
    chk("rst_ready", {31'd0, ifa.ready_o}, 1);
    chk("rst_valid", {31'd0, ifa.valid_o}, 0);
    chk("rst_data", int'(ifa.data_o), 0);
    @(negedge clk_i); @(negedge clk_i);
    rst_ni = 1'b1;
    foreach (dir[i]) run(dir[i], (i == 0) ? 10 : 1, got);
    repeat (10) run(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 3)), got);
    // abort a sample three cycles into the multiply
    wait_ready();
    drive(16384, 1'b1);
    @(posedge clk_i); #1;
    drive(0, 1'b0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b0;
    #1;
    chk("abort_valid", {31'd0, ifa.valid_o}, 0);
    chk("abort_data", int'(ifa.data_o), 0);
    chk("abort_ready", {31'd0, ifa.ready_o}, 1);
    @(negedge clk_i); @(negedge clk_i);
    rst_ni = 1'b1;
    run(16384, 2, got);
    // replay square-root stage outputs with downstream always ready
    set_ready(1'b1);
    repeat (30) begin
      x = int'($urandom_range(16, 32767));
      if ($urandom_range(0, 1) == 1) x = -x;
      s = isqrt(longint'(x < 0 ? -x : x) <<< 15);
      if (x > 0 && s > 32767) s = 32767;
      y = x < 0 ? -s : s;
      run(y, 0, got);
      chk("near", {31'd0, (got - x <= 2) && (x - got <= 2)}, 1);
      chk("sign", {31'd0, got < 0}, {31'd0, x < 0});
    end
    set_ready(1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
